// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - March C- element encodings, FSM states and per-element table
package mbist_pkg;

    typedef enum logic [2:0] {
        ELEM_NONE = 3'd0,
        ELEM_E1   = 3'd1,
        ELEM_E2   = 3'd2,
        ELEM_E3   = 3'd3,
        ELEM_E4   = 3'd4,
        ELEM_E5   = 3'd5,
        ELEM_E6   = 3'd6
    } elem_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_E1    = 4'd1,
        ST_E2_RD = 4'd2,
        ST_E2_WR = 4'd3,
        ST_E3_RD = 4'd4,
        ST_E3_WR = 4'd5,
        ST_PRE   = 4'd6,
        ST_E4_RD = 4'd7,
        ST_E4_WR = 4'd8,
        ST_E5_RD = 4'd9,
        ST_E5_WR = 4'd10,
        ST_E6    = 4'd11,
        ST_DRAIN = 4'd12,
        ST_DONE  = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        OPS_NONE = 2'd0,
        OPS_W    = 2'd1,
        OPS_R    = 2'd2,
        OPS_RW   = 2'd3
    } ops_e;

    // dir: 1 = walk the address space downward
    typedef struct packed {
        logic dir;
        ops_e ops;
        logic wval;
        logic rval;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input elem_e e);
        elem_cfg_t c;
        c = '{dir: 1'b0, ops: OPS_NONE, wval: 1'b0, rval: 1'b0};
        case (e)
            ELEM_E1: c = '{dir: 1'b0, ops: OPS_W,  wval: 1'b0, rval: 1'b0};
            ELEM_E2: c = '{dir: 1'b0, ops: OPS_RW, wval: 1'b1, rval: 1'b0};
            ELEM_E3: c = '{dir: 1'b0, ops: OPS_RW, wval: 1'b0, rval: 1'b1};
            ELEM_E4: c = '{dir: 1'b1, ops: OPS_RW, wval: 1'b1, rval: 1'b0};
            ELEM_E5: c = '{dir: 1'b1, ops: OPS_RW, wval: 1'b0, rval: 1'b1};
            ELEM_E6: c = '{dir: 1'b1, ops: OPS_R,  wval: 1'b0, rval: 1'b0};
            default: c = '{dir: 1'b0, ops: OPS_NONE, wval: 1'b0, rval: 1'b0};
        endcase
        return c;
    endfunction

    function automatic elem_e state_elem(input state_e s);
        elem_e e;
        case (s)
            ST_E1:              e = ELEM_E1;
            ST_E2_RD, ST_E2_WR: e = ELEM_E2;
            ST_E3_RD, ST_E3_WR: e = ELEM_E3;
            ST_E4_RD, ST_E4_WR: e = ELEM_E4;
            ST_E5_RD, ST_E5_WR: e = ELEM_E5;
            ST_E6:              e = ELEM_E6;
            default:            e = ELEM_NONE;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mbist_resp_cmp.sv
// rtl/mbist_resp_cmp.sv - read-data compare pipeline with sticky first-fail capture
module mbist_resp_cmp #(
    parameter int ADDR = 8,
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            cap_en,
    input  logic [DATA-1:0] exp,
    input  logic [ADDR-1:0] addr,
    input  logic [2:0]      elem,
    input  logic [DATA-1:0] rdata,
    output logic            bist_fail,
    output logic [ADDR-1:0] fail_addr,
    output logic [2:0]      fail_elem
);

    logic            pend_q, pend_d;
    logic [DATA-1:0] exp_q, exp_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [2:0]      elem_q, elem_d;
    logic            fail_q, fail_d;
    logic [ADDR-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]      fail_elem_q, fail_elem_d;
    logic            mismatch;

    // read data arrives one cycle after the read was issued
    assign mismatch = pend_q && (rdata != exp_q);

    // capture read context, then record only the first mismatch
    always_comb begin
        pend_d      = cap_en;
        exp_d       = exp_q;
        addr_d      = addr_q;
        elem_d      = elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        if (cap_en) begin
            exp_d  = exp;
            addr_d = addr;
            elem_d = elem;
        end
        if (clr) begin
            pend_d      = 1'b0;
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_elem_d = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = addr_q;
                fail_elem_d = elem_q;
            end
        end
    end

    // pipeline and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            exp_q       <= '0;
            addr_q      <= '0;
            elem_q      <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            pend_q      <= pend_d;
            exp_q       <= exp_d;
            addr_q      <= addr_d;
            elem_q      <= elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign bist_fail = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- sequencer: FSM, address-generator and memory op decode
module mbist_march_ctrl #(
    parameter int ADDR = 8,
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bist_start,
    output logic [1:0]      addr_en,
    output logic            addr_ff,
    input  logic            addr_done,
    input  logic [ADDR-1:0] addr,
    output logic            mem_we,
    output logic            mem_re,
    output logic [DATA-1:0] mem_wdata,
    input  logic [DATA-1:0] mem_rdata,
    output logic            bist_busy,
    output logic            bist_done,
    output logic            bist_fail,
    output logic [ADDR-1:0] fail_addr,
    output logic [2:0]      fail_elem
);
    import mbist_pkg::*;

    state_e          state_q, state_d;
    logic [1:0]      addr_en_q, addr_en_d;
    logic            addr_ff_q, addr_ff_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_re_q, mem_re_d;
    logic [DATA-1:0] mem_wdata_q, mem_wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_exp_q, rd_exp_d;
    logic [2:0]      rd_elem_q, rd_elem_d;

    elem_cfg_t       cfg_nxt;
    logic            start_acc;
    logic            adv, dir;

    assign start_acc = bist_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign cfg_nxt   = elem_cfg(state_elem(state_d));

    // element sequencing; addr_done is only meaningful in advancing states
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_E1;
            ST_E1:    if (addr_done) state_d = ST_E2_RD;
            ST_E2_RD: state_d = ST_E2_WR;
            ST_E2_WR: state_d = addr_done ? ST_E3_RD : ST_E2_RD;
            ST_E3_RD: state_d = ST_E3_WR;
            ST_E3_WR: state_d = addr_done ? ST_PRE : ST_E3_RD;
            ST_PRE:   state_d = ST_E4_RD;
            ST_E4_RD: state_d = ST_E4_WR;
            ST_E4_WR: state_d = addr_done ? ST_E5_RD : ST_E4_RD;
            ST_E5_RD: state_d = ST_E5_WR;
            ST_E5_WR: state_d = addr_done ? ST_E6 : ST_E5_RD;
            ST_E6:    if (addr_done) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (start_acc) state_d = ST_E1;
            default:  state_d = ST_IDLE;
        endcase
    end

    // outputs decoded from the next state so they are registered alongside it
    always_comb begin
        adv = 1'b0;
        dir = cfg_nxt.dir;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        case (state_d)
            ST_E1, ST_E6: begin
                adv      = 1'b1;
                mem_we_d = (cfg_nxt.ops == OPS_W);
                mem_re_d = (cfg_nxt.ops == OPS_R);
            end
            ST_E2_RD, ST_E3_RD, ST_E4_RD, ST_E5_RD: mem_re_d = 1'b1;
            ST_E2_WR, ST_E3_WR, ST_E4_WR, ST_E5_WR: begin
                adv      = 1'b1;
                mem_we_d = 1'b1;
            end
            // down-advance 0 -> MAX so E4 starts at the top
            ST_PRE: begin
                adv = 1'b1;
                dir = 1'b1;
            end
            // undo E6's 0 -> MAX wrap so a restart begins at address 0
            ST_DRAIN: adv = 1'b1;
            default: ;
        endcase
        addr_en_d   = {adv, dir};
        mem_wdata_d = mem_we_d ? {DATA{cfg_nxt.wval}} : '0;
        rd_exp_d    = cfg_nxt.rval;
        rd_elem_d   = state_elem(state_d);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        addr_ff_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_en_q   <= 2'b00;
            addr_ff_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_exp_q    <= 1'b0;
            rd_elem_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_en_q   <= addr_en_d;
            addr_ff_q   <= addr_ff_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_exp_q    <= rd_exp_d;
            rd_elem_q   <= rd_elem_d;
        end
    end

    mbist_resp_cmp #(
        .ADDR (ADDR),
        .DATA (DATA)
    ) u_resp_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_acc),
        .cap_en    (mem_re_q),
        .exp       ({DATA{rd_exp_q}}),
        .addr      (addr),
        .elem      (rd_elem_q),
        .rdata     (mem_rdata),
        .bist_fail (bist_fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    assign addr_en   = addr_en_q;
    assign addr_ff   = addr_ff_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_wdata = mem_wdata_q;
    assign bist_busy = busy_q;
    assign bist_done = done_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - scoreboard bench for mbist_march_ctrl with generator and SRAM models
module tb_mbist_march_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bist_start = 1'b0;
    logic [1:0]    addr_en;
    logic          addr_ff;
    logic          addr_done;
    logic [AW-1:0] addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          bist_busy;
    logic          bist_done;
    logic          bist_fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR(AW), .DATA(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bist_start (bist_start),
        .addr_en    (addr_en),
        .addr_ff    (addr_ff),
        .addr_done  (addr_done),
        .addr       (addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_fail  (bist_fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem)
    );

    // address generator: advance on addr_en[1], wrap at both ends
    logic [AW-1:0] gaddr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gaddr <= '0;
        else if (addr_en[1]) gaddr <= addr_en[0] ? gaddr - 1'b1 : gaddr + 1'b1;
    end
    assign addr      = gaddr;
    assign addr_done = addr_en[1] && (addr_en[0] ? (gaddr == '0) : (gaddr == {AW{1'b1}}));

    // synchronous SRAM with one optional stuck-at cell
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          flt_en = 1'b0;
    logic [AW-1:0] flt_addr = '0;
    logic [DW-1:0] sa1 = '0;
    logic [DW-1:0] sa0 = '0;
    always @(posedge clk) begin
        if (mem_we) mem[addr] <= mem_wdata;
        if (mem_re) mem_rdata <= (flt_en && addr == flt_addr) ? ((mem[addr] | sa1) & ~sa0) : mem[addr];
    end

    typedef struct {
        int lat; int fail; int faddr; int felem;
        int nwr; int nrd; int n11; int ndir; int pre_addr; int e4_addr;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // monitor: per-run trace statistics, scoreboard pop on bist_done rising
    int start_edge = 0, nwr = 0, nrd = 0, n11 = 0, ndir = 0, pre_addr = -1, e4_addr = -1, viol = 0;
    bit seen_pre = 0, seen_e4 = 0, dir_prev = 0, done_prev = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bist_start && !bist_busy) begin
            start_edge = edge_cnt + 1;
            nwr = 0; nrd = 0; n11 = 0; ndir = 0; viol = 0;
            pre_addr = -1; e4_addr = -1;
            seen_pre = 0; seen_e4 = 0; dir_prev = 0;
        end
        if (bist_busy) begin
            if (mem_we) nwr++;
            if (mem_re) nrd++;
            if (addr_en == 2'b11) n11++;
            if (addr_en[0]) ndir++;
            if (!seen_pre && addr_en == 2'b11 && !mem_we && !mem_re) begin
                seen_pre = 1; pre_addr = addr;
            end else if (seen_pre && !seen_e4 && mem_re) begin
                seen_e4 = 1; e4_addr = addr;
            end
            if (addr_en[0] != dir_prev && !(addr_en[1] && !mem_we && !mem_re)) viol++;
            dir_prev = addr_en[0];
            if (addr_ff) viol++;
        end
        if (bist_done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("sb_has_entry", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("latency", edge_cnt - start_edge, e.lat);
                chk("bist_fail", bist_fail, e.fail);
                chk("fail_addr", fail_addr, e.faddr);
                chk("fail_elem", fail_elem, e.felem);
                chk("writes", nwr, e.nwr);
                chk("reads", nrd, e.nrd);
                chk("en_11_cycles", n11, e.n11);
                chk("en_dir_cycles", ndir, e.ndir);
                chk("pre_addr", pre_addr, e.pre_addr);
                chk("e4_first_addr", e4_addr, e.e4_addr);
                chk("trace_viol", viol, 0);
                chk("busy_at_done", bist_busy, 0);
                chk("addr_ff_at_done", addr_ff, 1);
            end
        end
        done_prev = bist_done;
    end

    task automatic chk_reset();
        chk("rst_addr_ff", addr_ff, 1);
        chk("rst_addr_en", addr_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", bist_busy, 0);
        chk("rst_done", bist_done, 0);
        chk("rst_fail", bist_fail, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_elem", fail_elem, 0);
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 bist_start = 1'b1;
        @(posedge clk); #1 bist_start = 1'b0;
        chk("start_busy", bist_busy, 1);
        chk("start_done_clr", bist_done, 0);
        chk("start_fail_clr", bist_fail, 0);
        chk("start_felem_clr", fail_elem, 0);
    endtask

    // 16 cells: 80 writes, 80 reads, 49 cycles of 2'b11, 81 down-direction cycles
    task automatic run_full(input bit spurious, input int efail, input int efa, input int efe);
        exp_t e;
        e = '{lat: 162, fail: efail, faddr: efa, felem: efe, nwr: 80, nrd: 80,
              n11: 49, ndir: 81, pre_addr: 0, e4_addr: 15};
        sb.push_back(e);
        start_pulse();
        for (int i = 1; i <= 400 && !bist_done; i++) begin
            @(posedge clk); #1;
            bist_start = spurious && (i == 9 || i == 99);
        end
        bist_start = 1'b0;
        chk("done_seen", bist_done, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset();
        @(posedge clk); #1 rst_n = 1'b1;

        run_full(1'b1, 0, 0, 0);

        flt_en = 1'b1; flt_addr = 4'd5; sa1 = 8'h08; sa0 = 8'h00;
        run_full(1'b0, 1, 5, 2);

        flt_addr = 4'd15; sa1 = 8'h00; sa0 = 8'h01;
        run_full(1'b0, 1, 15, 3);

        flt_en = 1'b0; sa0 = 8'h00;
        run_full(1'b0, 0, 0, 0);

        start_pulse();
        repeat (49) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 chk_reset();

        run_full(1'b0, 0, 0, 0);

        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
